// File: rtl/regfile_write_queue_if.sv
// Producer, register-file write and forwarding signals of the register file
// write queue; master = producers/decode side, slave = the queue.
interface regfile_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  logic                     a_valid, a_ready;
  logic [AW-1:0]            a_sel;
  logic [DW-1:0]            a_dat;
  logic                     b_valid, b_ready;
  logic [AW-1:0]            b_sel;
  logic [DW-1:0]            b_dat;
  logic                     WEN;
  logic [AW-1:0]            wsel;
  logic [DW-1:0]            wdat;
  logic [AW-1:0]            q_rsel1, q_rsel2;
  logic                     fwd1_hit, fwd2_hit;
  logic [DW-1:0]            fwd1_dat, fwd2_dat;
  logic [$clog2(DEPTH):0]   count;
  logic                     full, empty;

  modport master (
    output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_rsel1, q_rsel2,
    input  a_ready, b_ready, WEN, wsel, wdat,
           fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat, count, full, empty
  );

  modport slave (
    input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_rsel1, q_rsel2,
    output a_ready, b_ready, WEN, wsel, wdat,
           fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat, count, full, empty
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Two-producer write queue in front of the register file's single write port,
// with youngest-entry forwarding for each decode read port.

module regfile_write_queue_fwd #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PW    = 2,
  parameter int CW    = 3
) (
  input  logic [DEPTH-1:0][AW-1:0] sel_q,
  input  logic [DEPTH-1:0][DW-1:0] dat_q,
  input  logic [PW-1:0]            head,
  input  logic [CW-1:0]            count,
  input  logic [AW-1:0]            rsel,
  output logic                     hit,
  output logic [DW-1:0]            dat
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest from head so the last match is the youngest one.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && rsel != '0 && sel_q[idx] == rsel) begin
        hit = 1'b1;
        dat = dat_q[idx];
      end
    end
  end
endmodule

module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input logic             CLK,
  input logic             nRST,
  regfile_write_queue_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NRP = 2;

  typedef struct packed {
    logic [AW-1:0] sel;
    logic [DW-1:0] dat;
  } req_t;

  logic [DEPTH-1:0][AW-1:0] sel_q;
  logic [DEPTH-1:0][DW-1:0] dat_q;
  logic [PW-1:0]            head, tail, b_idx;
  logic [CW-1:0]            count, free, count_nxt;
  req_t                     a_req, b_req;
  logic                     a_rdy, b_rdy, push_a, push_b, pop;

  logic [NRP-1:0][AW-1:0]   rsel;
  logic [NRP-1:0]           fwd_hit;
  logic [NRP-1:0][DW-1:0]   fwd_dat;

  assign a_req = '{sel: bus.a_sel, dat: bus.a_dat};
  assign b_req = '{sel: bus.b_sel, dat: bus.b_dat};

  // Credit comes from the registered count only; the same-cycle pop is ignored.
  assign free  = CW'(DEPTH) - count;
  assign a_rdy = free != '0;
  assign b_rdy = (free >= CW'(2)) || (free != '0 && !bus.a_valid);

  // Writes to r0 are handshaken but never occupy an entry.
  assign push_a = bus.a_valid && a_rdy && a_req.sel != '0;
  assign push_b = bus.b_valid && b_rdy && b_req.sel != '0;
  assign pop    = count != '0;
  assign b_idx  = tail + PW'(push_a);

  assign count_nxt = count + CW'(push_a) + CW'(push_b) - CW'(pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push_a) + PW'(push_b);
      count <= count_nxt;
    end
  end

  // Payload needs no reset: every consumer is qualified by count.
  always_ff @(posedge CLK) begin
    if (push_a) begin
      sel_q[tail] <= a_req.sel;
      dat_q[tail] <= a_req.dat;
    end
    if (push_b) begin
      sel_q[b_idx] <= b_req.sel;
      dat_q[b_idx] <= b_req.dat;
    end
  end

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.WEN     = pop;
  assign bus.wsel    = pop ? sel_q[head] : '0;
  assign bus.wdat    = pop ? dat_q[head] : '0;
  assign bus.count   = count;
  assign bus.full    = count == CW'(DEPTH);
  assign bus.empty   = count == '0;

  assign rsel = {bus.q_rsel2, bus.q_rsel1};

  for (genvar g = 0; g < NRP; g++) begin : g_fwd
    regfile_write_queue_fwd #(
      .DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW), .CW(CW)
    ) u_fwd (
      .sel_q (sel_q),
      .dat_q (dat_q),
      .head  (head),
      .count (count),
      .rsel  (rsel[g]),
      .hit   (fwd_hit[g]),
      .dat   (fwd_dat[g])
    );
  end

  assign bus.fwd1_hit = fwd_hit[0];
  assign bus.fwd1_dat = fwd_dat[0];
  assign bus.fwd2_hit = fwd_hit[1];
  assign bus.fwd2_dat = fwd_dat[1];
endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios plus a randomized run,
// all checked against a queue-based model of the write queue.
module tb_regfile_write_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  regfile_write_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

  regfile_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] sel;
    logic [DW-1:0] dat;
  } ent_t;

  ent_t mq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model: entries in program order, front = oldest.
  function automatic void model_fwd(input logic [AW-1:0] rs, output logic hit,
                                    output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0)
      for (int j = mq.size() - 1; j >= 0; j--)
        if (mq[j].sel == rs) begin
          hit = 1'b1;
          d   = mq[j].dat;
          break;
        end
  endfunction

  task automatic drive(input logic av, input logic [AW-1:0] as, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] bs, input logic [DW-1:0] bd);
    bus.a_valid = av; bus.a_sel = as; bus.a_dat = ad;
    bus.b_valid = bv; bus.b_sel = bs; bus.b_dat = bd;
    #1;
  endtask

  // One clock edge; the model applies the acceptance rules to the pre-edge state.
  task automatic tick();
    int   free;
    logic acc_a, acc_b;
    ent_t ea, eb;
    free  = DEPTH - mq.size();
    acc_a = bus.a_valid && free >= 1;
    acc_b = bus.b_valid && (free >= 2 || (free >= 1 && !bus.a_valid));
    ea = '{bus.a_sel, bus.a_dat};
    eb = '{bus.b_sel, bus.b_dat};
    @(posedge CLK);
    if (mq.size() != 0) void'(mq.pop_front());
    if (acc_a && ea.sel != 0) mq.push_back(ea);
    if (acc_b && eb.sel != 0) mq.push_back(eb);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.q_rsel1 = 5'd0; bus.q_rsel2 = 5'd0;
    #2;
    n_chk++;
    if ({bus.count, bus.empty, bus.full, bus.WEN, bus.wsel, bus.wdat} !== {3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0})
      $display("FAIL reset_state got cnt=%0d e=%b f=%b wen=%b ws=%0d wd=%h", bus.count, bus.empty, bus.full, bus.WEN, bus.wsel, bus.wdat);
    else n_pass++;
    n_chk++;
    if ({bus.fwd1_hit, bus.fwd2_hit, bus.fwd1_dat, bus.fwd2_dat} !== {2'b00, 64'd0})
      $display("FAIL reset_fwd got h1=%b h2=%b d1=%h d2=%h exp 0", bus.fwd1_hit, bus.fwd2_hit, bus.fwd1_dat, bus.fwd2_dat);
    else n_pass++;
    @(posedge CLK); #1 nRST = 1'b1;
    mq.delete();
    // Load three entries, then reset in the middle of a cycle.
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2); tick();
    drive(1, 5'd3, 32'h3, 1, 5'd4, 32'h4); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (bus.count !== 3'd3) $display("FAIL reset_preload count got %0d exp 3", bus.count);
    else n_pass++;
    #2 nRST = 1'b0;
    #1;
    mq.delete();
    n_chk++;
    if ({bus.count, bus.empty, bus.WEN} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL reset_async got cnt=%0d e=%b wen=%b exp 0/1/0", bus.count, bus.empty, bus.WEN);
    else n_pass++;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (bus.WEN !== 1'b0) $display("FAIL reset_no_write cyc=%0d WEN got %b exp 0", k, bus.WEN);
      else n_pass++;
    end
  endtask

  task automatic test_a_only();
    drive(1, 5'd5, 32'h11, 0, 0, 0);
    n_chk++;
    if (bus.a_ready !== 1'b1) $display("FAIL a_only_ready got %b exp 1", bus.a_ready);
    else n_pass++;
    tick();
    drive(1, 5'd6, 32'h22, 0, 0, 0);
    n_chk++;
    if ({bus.WEN, bus.wsel, bus.wdat, bus.count} !== {1'b1, 5'd5, 32'h11, 3'd1})
      $display("FAIL a_only_w1 got wen=%b ws=%0d wd=%h cnt=%0d exp 1/5/11/1", bus.WEN, bus.wsel, bus.wdat, bus.count);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({bus.WEN, bus.wsel, bus.wdat, bus.count} !== {1'b1, 5'd6, 32'h22, 3'd1})
      $display("FAIL a_only_w2 got wen=%b ws=%0d wd=%h cnt=%0d exp 1/6/22/1", bus.WEN, bus.wsel, bus.wdat, bus.count);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.WEN, bus.wsel, bus.wdat, bus.empty} !== {1'b0, 5'd0, 32'd0, 1'b1})
      $display("FAIL a_only_idle got wen=%b ws=%0d wd=%h e=%b exp 0/0/0/1", bus.WEN, bus.wsel, bus.wdat, bus.empty);
    else n_pass++;
  endtask

  task automatic test_ab_same();
    drive(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    n_chk++;
    if ({bus.a_ready, bus.b_ready} !== 2'b11) $display("FAIL ab_ready got %b exp 11", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    bus.q_rsel1 = 5'd3;
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({bus.count, bus.fwd1_hit, bus.fwd1_dat} !== {3'd2, 1'b1, 32'hBB})
      $display("FAIL ab_fwd got cnt=%0d hit=%b d=%h exp 2/1/bb", bus.count, bus.fwd1_hit, bus.fwd1_dat);
    else n_pass++;
    n_chk++;
    if ({bus.WEN, bus.wsel, bus.wdat} !== {1'b1, 5'd3, 32'hAA})
      $display("FAIL ab_drain1 got wen=%b ws=%0d wd=%h exp 1/3/aa", bus.WEN, bus.wsel, bus.wdat);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.WEN, bus.wsel, bus.wdat, bus.fwd1_dat} !== {1'b1, 5'd3, 32'hBB, 32'hBB})
      $display("FAIL ab_drain2 got wen=%b ws=%0d wd=%h f=%h exp 1/3/bb/bb", bus.WEN, bus.wsel, bus.wdat, bus.fwd1_dat);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.fwd1_hit, bus.fwd1_dat} !== {1'b0, 32'd0})
      $display("FAIL ab_fwd_clear got hit=%b d=%h exp 0/0", bus.fwd1_hit, bus.fwd1_dat);
    else n_pass++;
    bus.q_rsel1 = 5'd0;
  endtask

  task automatic test_fill_priority();
    drive(1, 5'd10, 32'h10, 1, 5'd11, 32'h11); tick();
    drive(1, 5'd12, 32'h12, 1, 5'd13, 32'h13); tick();
    drive(1, 5'd14, 32'h14, 1, 5'd15, 32'h15);
    n_chk++;
    if ({bus.count, bus.a_ready, bus.b_ready} !== {3'd3, 1'b1, 1'b0})
      $display("FAIL fill_prio got cnt=%0d ar=%b br=%b exp 3/1/0", bus.count, bus.a_ready, bus.b_ready);
    else n_pass++;
    tick();
    drive(0, 0, 0, 1, 5'd15, 32'h15);
    n_chk++;
    if ({bus.count, bus.wsel, bus.a_ready, bus.b_ready} !== {3'd3, 5'd12, 1'b1, 1'b1})
      $display("FAIL fill_b_alone got cnt=%0d ws=%0d ar=%b br=%b exp 3/12/1/1", bus.count, bus.wsel, bus.a_ready, bus.b_ready);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({bus.count, bus.full, bus.wsel} !== {3'd3, 1'b0, 5'd13})
      $display("FAIL fill_after_b got cnt=%0d f=%b ws=%0d exp 3/0/13", bus.count, bus.full, bus.wsel);
    else n_pass++;
    drain();
  endtask

  task automatic test_sel0();
    drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h102); tick();
    drive(1, 5'd3, 32'h103, 1, 5'd4, 32'h104); tick();
    drive(1, 5'd0, 32'hDEAD, 1, 5'd9, 32'h109);
    n_chk++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) $display("FAIL sel0_ready got %b exp 10", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({bus.count, bus.WEN, bus.wsel, bus.wdat} !== {3'd2, 1'b1, 5'd3, 32'h103})
      $display("FAIL sel0_drop got cnt=%0d wen=%b ws=%0d wd=%h exp 2/1/3/103", bus.count, bus.WEN, bus.wsel, bus.wdat);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.count, bus.wsel} !== {3'd1, 5'd4}) $display("FAIL sel0_tail got cnt=%0d ws=%0d exp 1/4", bus.count, bus.wsel);
    else n_pass++;
    drain();
  endtask

  task automatic test_wrap();
    // Fresh pointers so r7 lands on physical slots 3 and then 1.
    nRST = 1'b0; #1; mq.delete();
    @(posedge CLK); #1 nRST = 1'b1;
    drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2); tick();
    drive(1, 5'd4, 32'hA4, 1, 5'd7, 32'h1);  tick();
    drive(1, 5'd8, 32'hA8, 0, 0, 0);         tick();
    drive(1, 5'd7, 32'h2, 0, 0, 0);          tick();
    bus.q_rsel2 = 5'd7;
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({bus.fwd2_hit, bus.fwd2_dat, bus.wsel, bus.wdat} !== {1'b1, 32'h2, 5'd7, 32'h1})
      $display("FAIL wrap_fwd got hit=%b d=%h ws=%0d wd=%h exp 1/2/7/1", bus.fwd2_hit, bus.fwd2_dat, bus.wsel, bus.wdat);
    else n_pass++;
    tick(); tick();
    n_chk++;
    if ({bus.fwd2_hit, bus.fwd2_dat, bus.wdat} !== {1'b1, 32'h2, 32'h2})
      $display("FAIL wrap_last got hit=%b d=%h wd=%h exp 1/2/2", bus.fwd2_hit, bus.fwd2_dat, bus.wdat);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.fwd2_hit, bus.fwd2_dat} !== {1'b0, 32'd0})
      $display("FAIL wrap_clear got hit=%b d=%h exp 0/0", bus.fwd2_hit, bus.fwd2_dat);
    else n_pass++;
    bus.q_rsel2 = 5'd0;
  endtask

  task automatic test_random();
    int   ec, free;
    logic ear, ebr, h1, h2;
    logic [AW-1:0] ews;
    logic [DW-1:0] ewd, d1, d2;
    for (int c = 0; c < 500; c++) begin
      bus.q_rsel1 = 5'($urandom_range(0, 7));
      bus.q_rsel2 = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
      ec   = mq.size();
      free = DEPTH - ec;
      ear  = free >= 1;
      ebr  = free >= 2 || (free >= 1 && !bus.a_valid);
      ews  = (ec != 0) ? mq[0].sel : '0;
      ewd  = (ec != 0) ? mq[0].dat : '0;
      model_fwd(bus.q_rsel1, h1, d1);
      model_fwd(bus.q_rsel2, h2, d2);
      n_chk++;
      if ({bus.a_ready, bus.b_ready} !== {ear, ebr})
        $display("FAIL rnd_ready cyc=%0d got %b exp %b", c, {bus.a_ready, bus.b_ready}, {ear, ebr});
      else n_pass++;
      n_chk++;
      if ({bus.WEN, bus.wsel, bus.wdat} !== {(ec != 0), ews, ewd})
        $display("FAIL rnd_write cyc=%0d got %b/%0d/%h exp %b/%0d/%h", c, bus.WEN, bus.wsel, bus.wdat, (ec != 0), ews, ewd);
      else n_pass++;
      n_chk++;
      if ({bus.count, bus.empty, bus.full} !== {3'(ec), (ec == 0), (ec == DEPTH)})
        $display("FAIL rnd_count cyc=%0d got %0d/%b/%b exp %0d", c, bus.count, bus.empty, bus.full, ec);
      else n_pass++;
      n_chk++;
      if ({bus.fwd1_hit, bus.fwd1_dat, bus.fwd2_hit, bus.fwd2_dat} !== {h1, d1, h2, d2})
        $display("FAIL rnd_fwd cyc=%0d got %b/%h %b/%h exp %b/%h %b/%h", c, bus.fwd1_hit, bus.fwd1_dat,
                 bus.fwd2_hit, bus.fwd2_dat, h1, d1, h2, d2);
      else n_pass++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_ab_same();
    test_fill_priority();
    test_sel0();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
